// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: opcode/funct constants, state and aluop encodings, opcode decode helper.
package mips_mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] AC_AND = 4'b0000;
    localparam logic [3:0] AC_OR  = 4'b0001;
    localparam logic [3:0] AC_ADD = 4'b0010;
    localparam logic [3:0] AC_SUB = 4'b0110;
    localparam logic [3:0] AC_SLT = 4'b0111;
    localparam logic [3:0] AC_BAD = 4'b1111;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SB_REGB  = 2'b00;
    localparam logic [1:0] SB_FOUR  = 2'b01;
    localparam logic [1:0] SB_IMM   = 2'b10;
    localparam logic [1:0] SB_IMMSH = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } aluop_t;

    // An unknown opcode decodes back to FETCH; the caller flags that as illegal.
    function automatic state_t decode_op(input logic [5:0] op, input logic bne_en);
        return (op == OP_LW || op == OP_SW) ? S_MEMADR :
               (op == OP_RTYPE)             ? S_EXEC   :
               (op == OP_BEQ)               ? S_BRANCH :
               (op == OP_BNE && bne_en)     ? S_BRANCH :
               (op == OP_ADDI)              ? S_ADDIEX :
               (op == OP_J)                 ? S_JUMP   : S_FETCH;
    endfunction

endpackage

// File: rtl/mips_mc_alu_decoder.sv
// mips_mc_alu_decoder: combinational aluop/funct to 4-bit alucontrol.
module mips_mc_alu_decoder
    import mips_mc_pkg::*;
(
    input  aluop_t     i_aluop,
    input  logic [5:0] i_funct,
    output logic [3:0] o_alucontrol
);

    logic [3:0] w_funct_ctl;

    always_comb begin
        w_funct_ctl  = (i_funct == FN_ADD) ? AC_ADD :
                       (i_funct == FN_SUB) ? AC_SUB :
                       (i_funct == FN_AND) ? AC_AND :
                       (i_funct == FN_OR)  ? AC_OR  :
                       (i_funct == FN_SLT) ? AC_SLT : AC_BAD;
        o_alucontrol = (i_aluop == ALU_ADD)   ? AC_ADD :
                       (i_aluop == ALU_SUB)   ? AC_SUB :
                       (i_aluop == ALU_FUNCT) ? w_funct_ctl : AC_BAD;
    end

endmodule

// File: rtl/mips_multicycle_controller.sv
// mips_multicycle_controller: multicycle MIPS control FSM with memory stalls and retire counter.
// Define MIPS_MC_BNE_EN to decode bne (000101) as a branch on ~zero.
module mips_multicycle_controller
    import mips_mc_pkg::*;
#(
    parameter int ALUCTRL_W = 4,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 iord,
    output logic                 memwrite,
    output logic                 irwrite,
    output logic                 pcen,
    output logic [1:0]           pcsrc,
    output logic                 alusrca,
    output logic [1:0]           alusrcb,
    output logic                 regdst,
    output logic                 memtoreg,
    output logic                 regwrite,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic                 illegal_op,
    output logic [CNT_W-1:0]     instr_count
);

    state_t           r_state;
    state_t           w_next;
    state_t           w_dec;
    aluop_t           w_aluop;
    logic [3:0]       w_alu4;
    logic             w_bne_flag;
    logic             w_retire;
    logic [CNT_W-1:0] r_count;

`ifdef MIPS_MC_BNE_EN
    logic r_bne;
    assign w_bne_flag = r_bne;
    assign w_dec      = decode_op(opcode, 1'b1);
`else
    assign w_bne_flag = 1'b0;
    assign w_dec      = decode_op(opcode, 1'b0);
`endif

    assign instr_count = r_count;
    assign alucontrol  = ALUCTRL_W'(w_alu4);

    always_comb begin
        case (r_state)
            S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: w_next = w_dec;
            S_MEMADR: w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next = S_ALUWB;
            S_ADDIEX: w_next = S_ADDIWB;
            default:  w_next = S_FETCH;
        endcase
        // Illegal opcodes leave DECODE for FETCH too, but never retire.
        w_retire = (w_next == S_FETCH) && (r_state inside
                   {S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_count <= '0;
`ifdef MIPS_MC_BNE_EN
            r_bne   <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (w_retire)
                r_count <= r_count + 1'b1;
`ifdef MIPS_MC_BNE_EN
            if (r_state == S_DECODE)
                r_bne <= (opcode == OP_BNE);
`endif
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        pcen       = 1'b0;
        pcsrc      = PC_ALU;
        alusrca    = 1'b0;
        alusrcb    = SB_REGB;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        w_aluop    = ALU_ADD;
        illegal_op = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                alusrcb = SB_FOUR;
                irwrite = mem_ready;
                pcen    = mem_ready;
            end
            S_DECODE: begin
                alusrcb    = SB_IMMSH;
                illegal_op = (w_dec == S_FETCH);
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SB_IMM;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                w_aluop = ALU_FUNCT;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                w_aluop = ALU_SUB;
                pcsrc   = PC_ALUOUT;
                pcen    = zero ^ w_bne_flag;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JUMP: begin
                pcsrc = PC_JUMP;
                pcen  = 1'b1;
            end
            default: ;
        endcase
    end

    mips_mc_alu_decoder u_alu_dec (
        .i_aluop      (w_aluop),
        .i_funct      (funct),
        .o_alucontrol (w_alu4)
    );

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// tb_mips_multicycle_controller: directed checks of the multicycle controller state sequencing.
module tb_mips_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, iord, memwrite, irwrite, pcen;
    logic [1:0]  pcsrc, alusrcb;
    logic        alusrca, regdst, memtoreg, regwrite, illegal_op;
    logic [3:0]  alucontrol;
    logic [31:0] instr_count;
    logic [13:0] w_ctl;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    mips_multicycle_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .iord        (iord),
        .memwrite    (memwrite),
        .irwrite     (irwrite),
        .pcen        (pcen),
        .pcsrc       (pcsrc),
        .alusrca     (alusrca),
        .alusrcb     (alusrcb),
        .regdst      (regdst),
        .memtoreg    (memtoreg),
        .regwrite    (regwrite),
        .alucontrol  (alucontrol),
        .illegal_op  (illegal_op),
        .instr_count (instr_count)
    );

    assign w_ctl = {mem_req, iord, memwrite, irwrite, pcen, pcsrc, alusrca,
                    alusrcb, regdst, memtoreg, regwrite, illegal_op};

    function automatic logic [13:0] ctl(input logic mr, io, mw, ir, pe, input logic [1:0] ps,
                                        input logic sa, input logic [1:0] sb,
                                        input logic rd, mt, rw, il);
        return {mr, io, mw, ir, pe, ps, sa, sb, rd, mt, rw, il};
    endfunction

    localparam logic [13:0] F_RDY   = ctl(1,0,0,1,1,2'b00,0,2'b01,0,0,0,0);
    localparam logic [13:0] F_WAIT  = ctl(1,0,0,0,0,2'b00,0,2'b01,0,0,0,0);
    localparam logic [13:0] DEC     = ctl(0,0,0,0,0,2'b00,0,2'b11,0,0,0,0);
    localparam logic [13:0] DEC_ILL = ctl(0,0,0,0,0,2'b00,0,2'b11,0,0,0,1);
    localparam logic [13:0] MADR    = ctl(0,0,0,0,0,2'b00,1,2'b10,0,0,0,0);
    localparam logic [13:0] MRD     = ctl(1,1,0,0,0,2'b00,0,2'b00,0,0,0,0);
    localparam logic [13:0] MWB     = ctl(0,0,0,0,0,2'b00,0,2'b00,0,1,1,0);
    localparam logic [13:0] MWR     = ctl(1,1,1,0,0,2'b00,0,2'b00,0,0,0,0);
    localparam logic [13:0] EXE     = ctl(0,0,0,0,0,2'b00,1,2'b00,0,0,0,0);
    localparam logic [13:0] AWB     = ctl(0,0,0,0,0,2'b00,0,2'b00,1,0,1,0);
    localparam logic [13:0] BR_T    = ctl(0,0,0,0,1,2'b01,1,2'b00,0,0,0,0);
    localparam logic [13:0] BR_N    = ctl(0,0,0,0,0,2'b01,1,2'b00,0,0,0,0);
    localparam logic [13:0] AIWB    = ctl(0,0,0,0,0,2'b00,0,2'b00,0,0,1,0);

`ifdef MIPS_MC_BNE_EN
    localparam int BNE_RET = 1;
`else
    localparam int BNE_RET = 0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Check the current state's outputs, then advance one clock.
    task automatic cyc(input string tag, input logic [13:0] exp_ctl, input logic [3:0] exp_alu);
        #1;
        check(tag, 32'(w_ctl), 32'(exp_ctl));
        check({tag, "_alu"}, 32'(alucontrol), 32'(exp_alu));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; opcode = 6'b0; funct = 6'b0; zero = 1'b0; mem_ready = 1'b0;
        #1;
        check("rst_ctl", 32'(w_ctl), 32'(F_WAIT));
        check("rst_cnt", instr_count, 0);
        #20 rst_n = 1'b1;

        opcode = 6'b100011; mem_ready = 1'b1;
        cyc("lw_f", F_RDY, 4'b0010);
        cyc("lw_d", DEC, 4'b0010);
        cyc("lw_a", MADR, 4'b0010);
        cyc("lw_r", MRD, 4'b0010);
        cyc("lw_wb", MWB, 4'b0010);
        check("lw_cnt", instr_count, 1);

        opcode = 6'b000100; zero = 1'b1;
        cyc("beq1_f", F_RDY, 4'b0010);
        cyc("beq1_d", DEC, 4'b0010);
        cyc("beq1_br", BR_T, 4'b0110);
        zero = 1'b0;
        cyc("beq0_f", F_RDY, 4'b0010);
        cyc("beq0_d", DEC, 4'b0010);
        cyc("beq0_br", BR_N, 4'b0110);
        check("beq_cnt", instr_count, 3);

        opcode = 6'b000000; funct = 6'b101010;
        cyc("slt_f", F_RDY, 4'b0010);
        cyc("slt_d", DEC, 4'b0010);
        cyc("slt_ex", EXE, 4'b0111);
        cyc("slt_wb", AWB, 4'b0010);
        funct = 6'b100111;
        cyc("nor_f", F_RDY, 4'b0010);
        cyc("nor_d", DEC, 4'b0010);
        cyc("nor_ex", EXE, 4'b1111);
        cyc("nor_wb", AWB, 4'b0010);
        check("r_cnt", instr_count, 5);

        opcode = 6'b000101; zero = 1'b0;
        cyc("bne_f", F_RDY, 4'b0010);
`ifdef MIPS_MC_BNE_EN
        cyc("bne_d", DEC, 4'b0010);
        cyc("bne_br", BR_T, 4'b0110);
`else
        cyc("bne_ill", DEC_ILL, 4'b0010);
`endif
        check("bne_cnt", instr_count, 32'(5 + BNE_RET));

        opcode = 6'b001000; mem_ready = 1'b0;
        cyc("addi_w1", F_WAIT, 4'b0010);
        cyc("addi_w2", F_WAIT, 4'b0010);
        cyc("addi_w3", F_WAIT, 4'b0010);
        mem_ready = 1'b1;
        cyc("addi_f", F_RDY, 4'b0010);
        cyc("addi_d", DEC, 4'b0010);
        cyc("addi_ex", MADR, 4'b0010);
        cyc("addi_wb", AIWB, 4'b0010);
        check("addi_cnt", instr_count, 32'(6 + BNE_RET));

        opcode = 6'b101011;
        cyc("sw_f", F_RDY, 4'b0010);
        cyc("sw_d", DEC, 4'b0010);
        mem_ready = 1'b0;
        cyc("sw_a", MADR, 4'b0010);
        cyc("sw_w1", MWR, 4'b0010);
        #1 check("sw_stall_mw", 32'(memwrite), 1);
        check("sw_stall_cnt", instr_count, 32'(6 + BNE_RET));
        #1 rst_n = 1'b0;
        #1 check("rst_mw", 32'(memwrite), 0);
        check("rst_mid_ctl", 32'(w_ctl), 32'(F_WAIT));
        check("rst_mid_cnt", instr_count, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc("post_rst_f", F_WAIT, 4'b0010);

        mem_ready = 1'b1;
        cyc("sw2_f", F_RDY, 4'b0010);
        cyc("sw2_d", DEC, 4'b0010);
        cyc("sw2_a", MADR, 4'b0010);
        cyc("sw2_w", MWR, 4'b0010);
        check("sw2_cnt", instr_count, 1);
        cyc("sw2_next_f", F_RDY, 4'b0010);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
